sram_imc_wb_ctrl: RTL

Parametrised Wishbone slave controller for the SRAM in-memory-compute (IMC) macros, placed inside `user_project_wrapper` between the Caravel Wishbone bus and `NUM_BANKS` SRAM_IMC macro instances. It supersedes the single-macro hookup with:
- multi-bank address decode, byte-masked writes and configurable read wait states;
- a CSR-controlled IMC compute sequencer that drives the clamp-enable and compute-enable lines;
- a done interrupt.

---
 rtl/sram_imc_pkg.sv | 18 +
 rtl/sram_imc_seq.sv | 85 ++++++++
 rtl/sram_imc_wb_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sram_imc_pkg.sv
// Shared FSM state types and CSR map for the SRAM IMC Wishbone controller.
package sram_imc_pkg;

  typedef enum logic [1:0] {IDLE, MEM_RD, MEM_WR, ACK} bus_state_e;
  typedef enum logic [1:0] {I_IDLE, I_VCLP, I_RUN} imc_state_e;

  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_STATUS = 2'd1;
  localparam logic [1:0] CSR_CYCLES = 2'd2;

  localparam int CTRL_MASK_W     = 8;
  localparam int CTRL_IRQ_EN_BIT = 30;
  localparam int CTRL_START_BIT  = 31;
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;
  localparam int STAT_ERR_BIT    = 2;

endpackage

// File: rtl/sram_imc_seq.sv
// IMC compute sequencer: clamp precharge, then compute enable on the latched
// bank mask, with a wrapping count of completed runs.
//
//   state  | meaning
//   I_IDLE | waiting for a start with a nonzero mask
//   I_VCLP | clamp precharge, imc_vclp_en only
//   I_RUN  | clamp held, imc_en driven with the latched mask
module sram_imc_seq
  import sram_imc_pkg::*;
#(
  parameter int NUM_BANKS   = 4,
  parameter int VCLP_CYCLES = 4,
  parameter int IMC_CYCLES  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [NUM_BANKS-1:0] mask_i,
  output logic                 busy_o,
  output logic                 done_pulse_o,
  output logic                 imc_vclp_en_o,
  output logic [NUM_BANKS-1:0] imc_en_o,
  output logic [15:0]          cycles_o
);

  localparam int MAXC  = (VCLP_CYCLES > IMC_CYCLES) ? VCLP_CYCLES : IMC_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  imc_state_e           state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_BANKS-1:0] mask_q;
  logic                 vclp_q;
  logic [NUM_BANKS-1:0] en_q;
  logic [15:0]          cycles_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= I_IDLE;
      cnt_q    <= '0;
      mask_q   <= '0;
      vclp_q   <= 1'b0;
      en_q     <= '0;
      cycles_q <= '0;
    end else begin
      case (state_q)
        I_IDLE: begin
          if (start_i && (mask_i != '0)) begin
            state_q <= I_VCLP;
            cnt_q   <= CNT_W'(VCLP_CYCLES - 1);
            mask_q  <= mask_i;
            vclp_q  <= 1'b1;
          end
        end
        I_VCLP: begin
          if (cnt_q == '0) begin
            state_q <= I_RUN;
            cnt_q   <= CNT_W'(IMC_CYCLES - 1);
            en_q    <= mask_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        I_RUN: begin
          if (cnt_q == '0) begin
            state_q  <= I_IDLE;
            vclp_q   <= 1'b0;
            en_q     <= '0;
            cycles_q <= cycles_q + 16'd1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= I_IDLE;
      endcase
    end
  end

  // Combinational so the CSR done bit lands on the same edge the run ends.
  assign done_pulse_o  = (state_q == I_RUN) && (cnt_q == '0);
  assign busy_o        = (state_q != I_IDLE);
  assign imc_vclp_en_o = vclp_q;
  assign imc_en_o      = en_q;
  assign cycles_o      = cycles_q;

endmodule

// File: rtl/sram_imc_wb_ctrl.sv
// Wishbone slave for NUM_BANKS SRAM IMC macros: address decode, bus FSM,
// CSRs and read mux; the compute sequence lives in sram_imc_seq.
//
//   state  | meaning
//   IDLE   | accepting requests, stalls memory access to busy masked banks
//   MEM_RD | read strobe issued, counting read wait states
//   MEM_WR | write strobe issued
//   ACK    | one-cycle acknowledge
module sram_imc_wb_ctrl
  import sram_imc_pkg::*;
#(
  parameter int          NUM_BANKS   = 4,
  parameter int          ADDR_W      = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          RD_WAIT     = 2,
  parameter int          VCLP_CYCLES = 4,
  parameter int          IMC_CYCLES  = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic [NUM_BANKS-1:0]   mem_en,
  output logic                   mem_we,
  output logic [3:0]             mem_wmask,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [32*NUM_BANKS-1:0] mem_rdata,
  output logic                   imc_vclp_en,
  output logic [NUM_BANKS-1:0]   imc_en,
  output logic                   irq
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [7:0] BANK_VALID = 8'((1 << NUM_BANKS) - 1);

  bus_state_e           state_q;
  logic                 ack_q, mem_we_q, start_q, irq_en_q, done_q, err_q;
  logic [31:0]          dat_q, mem_wdata_q;
  logic [NUM_BANKS-1:0] mem_en_q;
  logic [3:0]           mem_wmask_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [BANK_W-1:0]    bank_q;
  logic [2:0]           wait_q;
  logic [7:0]           ctrl_mask_q;

  logic                 busy, done_pulse;
  logic [15:0]          cycles;
  logic                 req, hit, is_csr, oor, idle_req;
  logic                 csr_wr, ctrl_wr, stat_wr, bad_acc, start_d, zero_start;
  logic [BANK_W-1:0]    bank;
  logic [NUM_BANKS-1:0] bank_oh;
  logic [7:0]           eff_mask;
  logic [31:0]          csr_rdata_d, rd_slice;
  logic                 unused_bits;

  assign req      = wbs_cyc_i & wbs_stb_i;
  assign idle_req = (state_q == IDLE) && req;
  assign hit      = (wbs_adr_i[31:24] == BASE_ADDR[31:24]);
  assign is_csr   = wbs_adr_i[20];
  assign bank     = wbs_adr_i[ADDR_W+BANK_W+1:ADDR_W+2];
  assign oor      = (32'(bank) >= NUM_BANKS);
  assign bank_oh  = NUM_BANKS'(1) << bank;
  assign rd_slice = mem_rdata[{bank_q, 5'b0} +: 32];
  assign unused_bits = ^{wbs_adr_i, wbs_dat_i};

  assign csr_wr     = idle_req && hit && is_csr && wbs_we_i;
  assign ctrl_wr    = csr_wr && (wbs_adr_i[3:2] == CSR_CTRL);
  assign stat_wr    = csr_wr && (wbs_adr_i[3:2] == CSR_STATUS);
  assign bad_acc    = idle_req && (!hit || (!is_csr && oor));
  assign eff_mask   = wbs_dat_i[CTRL_MASK_W-1:0] & BANK_VALID;
  assign start_d    = ctrl_wr && wbs_dat_i[CTRL_START_BIT] && !busy && (eff_mask != '0);
  assign zero_start = ctrl_wr && wbs_dat_i[CTRL_START_BIT] && !busy && (eff_mask == '0);

  always_comb begin
    csr_rdata_d = '0;
    case (wbs_adr_i[3:2])
      CSR_CTRL: begin
        csr_rdata_d[CTRL_MASK_W-1:0]  = ctrl_mask_q;
        csr_rdata_d[CTRL_IRQ_EN_BIT]  = irq_en_q;
      end
      CSR_STATUS: begin
        csr_rdata_d[STAT_BUSY_BIT] = busy;
        csr_rdata_d[STAT_DONE_BIT] = done_q;
        csr_rdata_d[STAT_ERR_BIT]  = err_q;
      end
      CSR_CYCLES: csr_rdata_d[15:0] = cycles;
      default: csr_rdata_d = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      mem_en_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_wmask_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      bank_q      <= '0;
      wait_q      <= '0;
      ctrl_mask_q <= '0;
      irq_en_q    <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      start_q  <= start_d;
      // A coincident set beats the W1C clear.
      done_q   <= done_pulse | (done_q & ~(stat_wr & wbs_dat_i[STAT_DONE_BIT]));
      err_q    <= bad_acc | zero_start | (err_q & ~(stat_wr & wbs_dat_i[STAT_ERR_BIT]));
      if (ctrl_wr) begin
        ctrl_mask_q <= wbs_dat_i[CTRL_MASK_W-1:0];
        irq_en_q    <= wbs_dat_i[CTRL_IRQ_EN_BIT];
      end
      ack_q    <= 1'b0;
      mem_en_q <= '0;
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (!hit || is_csr || oor) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
              if (!wbs_we_i) dat_q <= (hit && is_csr) ? csr_rdata_d : '0;
            end else if (!(busy && ctrl_mask_q[bank])) begin
              state_q     <= wbs_we_i ? MEM_WR : MEM_RD;
              mem_en_q    <= bank_oh;
              mem_we_q    <= wbs_we_i;
              mem_addr_q  <= wbs_adr_i[ADDR_W+1:2];
              mem_wmask_q <= wbs_sel_i;
              mem_wdata_q <= wbs_dat_i;
              bank_q      <= bank;
              wait_q      <= 3'(RD_WAIT);
            end
          end
        end
        MEM_WR: begin
          state_q <= ACK;
          ack_q   <= 1'b1;
        end
        MEM_RD: begin
          if (wait_q == '0) begin
            dat_q   <= rd_slice;
            state_q <= ACK;
            ack_q   <= 1'b1;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  sram_imc_seq #(
    .NUM_BANKS  (NUM_BANKS),
    .VCLP_CYCLES(VCLP_CYCLES),
    .IMC_CYCLES (IMC_CYCLES)
  ) u_seq (
    .clk_i        (wb_clk_i),
    .rst_i        (wb_rst_i),
    .start_i      (start_q),
    .mask_i       (ctrl_mask_q[NUM_BANKS-1:0]),
    .busy_o       (busy),
    .done_pulse_o (done_pulse),
    .imc_vclp_en_o(imc_vclp_en),
    .imc_en_o     (imc_en),
    .cycles_o     (cycles)
  );

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign irq       = done_q & irq_en_q;

endmodule
